// File: rtl/icebus_responder.sv
// icebus_responder
//   Motor-board end of the icebus serial link. Receives 8N1 command frames
//   (55 ID D0 D1 D2 D3 CHK), presents the commanded setpoint, and answers
//   frames addressed to DEVICE_ID with a status frame
//   (AA DEVICE_ID C0 C1 C2 C3 CHK) carrying the sampled current value.
//   The line is half duplex: tx_enable drives the RS-485 transceiver.
//
//   Build option: ICEBUS_CRC8_EN
//     undefined : CHK = XOR of ID and the four payload bytes
//     defined   : CHK = CRC-8 (poly 0x07, init 0x00, MSB first) over the
//                 same five bytes, accumulated bytewise
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-high reset
//   rx              serial input (idle high, asynchronous to clk)
//   tx              serial output (idle high)
//   tx_enable       RS-485 driver enable
//   current_in      current value reported in the response
//   setpoint        last accepted setpoint
//   setpoint_valid  one-cycle pulse when setpoint updates
//   frame_error     one-cycle pulse on framing, checksum or timeout error

module icebus_responder #(
  parameter int         CLK_FREQ        = 50000000,
  parameter int         BAUD            = 1000000,
  parameter logic [7:0] DEVICE_ID       = 8'h01,
  parameter int         TURNAROUND_BITS = 2,
  parameter int         TIMEOUT_BITS    = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        tx,
  output logic        tx_enable,
  input  logic [31:0] current_in,
  output logic [31:0] setpoint,
  output logic        setpoint_valid,
  output logic        frame_error
);

  // CLKS_PER_BIT must be >= 8 for the mid-bit sampling to be meaningful.
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;
  // tx_enable rises in the cycle after the CHK stop sample; the start bit
  // must begin TURNAROUND_BITS bit periods after that sample, hence the -1.
  localparam int TURN_CYC = (TURNAROUND_BITS * CPB > 1) ? TURNAROUND_BITS * CPB - 1 : 1;
  localparam int TMO_CYC  = TIMEOUT_BITS * CPB;
  localparam int BW       = $clog2(CPB + 1);
  localparam int TW       = $clog2(TMO_CYC + 1);
  localparam int CW       = $clog2(((TURN_CYC > CPB) ? TURN_CYC : CPB) + 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  typedef enum logic [2:0] {P_SYNC, P_ID, P_D0, P_D1, P_D2, P_D3, P_CHK} p_st_t;
  typedef enum logic [1:0] {T_IDLE, T_TURN, T_SEND, T_REL} tx_st_t;

  // Checksum accumulator step, shared by the parser and the transmitter.
  function automatic logic [7:0] chk_upd(input logic [7:0] acc, input logic [7:0] b);
`ifdef ICEBUS_CRC8_EN
    logic [7:0] c;
    c = acc ^ b;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
`else
    return acc ^ b;
`endif
  endfunction

  // ---------------------------------------------------------------------
  // rx synchroniser; third flop gives the falling-edge detector its history
  // ---------------------------------------------------------------------
  logic rx_s1, rx_s2, rx_s3;
  logic rx_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) {rx_s3, rx_s2, rx_s1} <= 3'b111;
    else       {rx_s3, rx_s2, rx_s1} <= {rx_s2, rx_s1, rx};
  end

  assign rx_fall = rx_s3 & ~rx_s2;

  // ---------------------------------------------------------------------
  // rx byte receiver
  // ---------------------------------------------------------------------
  rx_st_t          r_st;
  logic [BW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_sh;
  logic [7:0]      rx_byte;
  logic            rx_done;   // good byte in rx_byte
  logic            rx_ferr;   // stop bit sampled low
  logic            rx_start;  // start bit confirmed at mid-bit

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st     <= R_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_sh     <= '0;
      rx_byte  <= '0;
      rx_done  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_start <= 1'b0;
    end else begin
      rx_done  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_start <= 1'b0;
      unique case (r_st)
        R_IDLE: begin
          if (rx_fall) begin
            r_st  <= R_START;
            r_cnt <= '0;
          end
        end
        R_START: begin
          if (r_cnt == BW'(HALF - 1)) begin
            r_cnt <= '0;
            // A line that is high again at mid-start was a glitch.
            if (!rx_s2) begin
              r_st     <= R_DATA;
              r_bit    <= '0;
              rx_start <= 1'b1;
            end else begin
              r_st <= R_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (r_cnt == BW'(CPB - 1)) begin
            r_cnt <= '0;
            r_sh  <= {rx_s2, r_sh[7:1]};
            r_bit <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_st <= R_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (r_cnt == BW'(CPB - 1)) begin
            r_cnt <= '0;
            r_st  <= R_IDLE;
            if (rx_s2) begin
              rx_done <= 1'b1;
              rx_byte <= r_sh;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_st <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Command frame parser
  // ---------------------------------------------------------------------
  p_st_t         p_st;
  logic [7:0]    p_id;
  logic [31:0]   p_data;
  logic [7:0]    p_acc;
  logic [TW-1:0] tmo;
  logic          id_hit;
  logic          good_frame;
  logic          resp_go;
  tx_st_t        t_st;

  assign id_hit     = (p_id == DEVICE_ID) || (p_id == 8'hFF);
  assign good_frame = rx_done && (p_st == P_CHK) && id_hit && (rx_byte == p_acc);
  // Responses are never queued: a frame finishing while tx is busy is
  // still applied to setpoint but goes unanswered.
  assign resp_go    = good_frame && (p_id == DEVICE_ID) && (t_st == T_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_st           <= P_SYNC;
      p_id           <= '0;
      p_data         <= '0;
      p_acc          <= '0;
      tmo            <= '0;
      setpoint       <= '0;
      setpoint_valid <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      setpoint_valid <= 1'b0;
      frame_error    <= 1'b0;

      // Idle-gap timer, restarted by every confirmed start bit.
      if (p_st == P_SYNC || rx_start) tmo <= '0;
      else                            tmo <= tmo + 1'b1;

      if (rx_ferr) begin
        frame_error <= 1'b1;
        p_st        <= P_SYNC;
      end else if (rx_done) begin
        unique case (p_st)
          P_SYNC: if (rx_byte == 8'h55) p_st <= P_ID;
          P_ID: begin
            p_id  <= rx_byte;
            p_acc <= chk_upd(8'h00, rx_byte);
            p_st  <= P_D0;
          end
          P_D0: begin
            p_data[7:0] <= rx_byte;
            p_acc       <= chk_upd(p_acc, rx_byte);
            p_st        <= P_D1;
          end
          P_D1: begin
            p_data[15:8] <= rx_byte;
            p_acc        <= chk_upd(p_acc, rx_byte);
            p_st         <= P_D2;
          end
          P_D2: begin
            p_data[23:16] <= rx_byte;
            p_acc         <= chk_upd(p_acc, rx_byte);
            p_st          <= P_D3;
          end
          P_D3: begin
            p_data[31:24] <= rx_byte;
            p_acc         <= chk_upd(p_acc, rx_byte);
            p_st          <= P_CHK;
          end
          P_CHK: begin
            p_st <= P_SYNC;
            // Frames for other nodes are consumed silently.
            if (id_hit) begin
              if (rx_byte == p_acc) begin
                setpoint       <= p_data;
                setpoint_valid <= 1'b1;
              end else begin
                frame_error <= 1'b1;
              end
            end
          end
          default: p_st <= P_SYNC;
        endcase
      end else if (p_st != P_SYNC && !rx_start && tmo == TW'(TMO_CYC - 1)) begin
        frame_error <= 1'b1;
        p_st        <= P_SYNC;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Response transmitter
  // ---------------------------------------------------------------------
  logic [CW-1:0] t_cnt;
  logic [3:0]    t_bit;     // 0 = start bit on the line, 9 = stop bit
  logic [8:0]    t_sh;      // remaining data bits followed by the stop bit
  logic [2:0]    t_idx;     // byte currently on the line
  logic [2:0]    nxt_idx;
  logic [7:0]    nxt_byte;
  logic [31:0]   t_cur;
  logic [7:0]    t_acc;

  assign nxt_idx = t_idx + 3'd1;

  always_comb begin
    nxt_byte = 8'hAA;
    unique case (nxt_idx)
      3'd1:    nxt_byte = DEVICE_ID;
      3'd2:    nxt_byte = t_cur[7:0];
      3'd3:    nxt_byte = t_cur[15:8];
      3'd4:    nxt_byte = t_cur[23:16];
      3'd5:    nxt_byte = t_cur[31:24];
      3'd6:    nxt_byte = t_acc;
      default: nxt_byte = 8'hAA;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_st      <= T_IDLE;
      t_cnt     <= '0;
      t_bit     <= '0;
      t_sh      <= '1;
      t_idx     <= '0;
      t_cur     <= '0;
      t_acc     <= '0;
      tx        <= 1'b1;
      tx_enable <= 1'b0;
    end else begin
      unique case (t_st)
        T_IDLE: begin
          if (resp_go) begin
            t_st      <= T_TURN;
            tx_enable <= 1'b1;
            t_cnt     <= '0;
            t_cur     <= current_in;
            t_acc     <= '0;
            t_idx     <= '0;
          end
        end
        T_TURN: begin
          if (t_cnt == CW'(TURN_CYC - 1)) begin
            t_st  <= T_SEND;
            t_cnt <= '0;
            tx    <= 1'b0;
            t_sh  <= {1'b1, 8'hAA};
            t_bit <= '0;
          end else begin
            t_cnt <= t_cnt + 1'b1;
          end
        end
        T_SEND: begin
          if (t_cnt == CW'(CPB - 1)) begin
            t_cnt <= '0;
            if (t_bit != 4'd9) begin
              tx    <= t_sh[0];
              t_sh  <= {1'b1, t_sh[8:1]};
              t_bit <= t_bit + 4'd1;
            end else if (t_idx != 3'd6) begin
              // Next start bit follows the stop bit with no idle gap.
              t_idx <= nxt_idx;
              tx    <= 1'b0;
              t_sh  <= {1'b1, nxt_byte};
              t_bit <= '0;
              if (nxt_idx <= 3'd5) t_acc <= chk_upd(t_acc, nxt_byte);
            end else begin
              t_st <= T_REL;
            end
          end else begin
            t_cnt <= t_cnt + 1'b1;
          end
        end
        T_REL: begin
          if (t_cnt == CW'(CPB - 1)) begin
            t_cnt     <= '0;
            tx_enable <= 1'b0;
            t_st      <= T_IDLE;
          end else begin
            t_cnt <= t_cnt + 1'b1;
          end
        end
        default: t_st <= T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icebus_responder.sv
// Bench for icebus_responder: directed protocol scenarios plus randomised
// frames, checked against a byte-level reference of the icebus protocol.
module tb_icebus_responder;
  localparam int CPB = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        tx;
  logic        tx_enable;
  logic [31:0] current_in;
  logic [31:0] setpoint;
  logic        setpoint_valid;
  logic        frame_error;

  always #5 clk = ~clk;

  icebus_responder #(
    .CLK_FREQ(50000000), .BAUD(1000000), .DEVICE_ID(8'h01),
    .TURNAROUND_BITS(2), .TIMEOUT_BITS(20)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx), .tx_enable(tx_enable),
    .current_in(current_in), .setpoint(setpoint),
    .setpoint_valid(setpoint_valid), .frame_error(frame_error)
  );

  int vectors = 0;
  int miscompares = 0;

  // Observation: cycle counter, pulse counters, tx_enable edges.
  int cyc = 0;
  int sv_cnt = 0, sv_cyc = 0, fe_cnt = 0, fe_cyc = 0;
  int ten_rise = 0, ten_fall_cyc = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (setpoint_valid === 1'b1) begin sv_cnt++; sv_cyc = cyc; end
    if (frame_error === 1'b1)    begin fe_cnt++; fe_cyc = cyc; end
  end

  always @(posedge tx_enable) ten_rise++;
  always @(negedge tx_enable) ten_fall_cyc = cyc;

  // UART decoder on tx: records each byte and the cycle its start bit began.
  logic [7:0] rsp_q[$];
  int         rsp_t[$];

  always begin : tx_decoder
    logic [7:0] b;
    int t0;
    @(negedge tx);
    t0 = cyc;
    repeat (CPB / 2) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      b[i] = tx;
    end
    repeat (CPB) @(posedge clk);
    rsp_q.push_back(b);
    rsp_t.push_back(t0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Checksum over the 5-byte message ID, V[7:0], V[15:8], V[23:16], V[31:24].
  function automatic logic [7:0] ref_chk(input logic [7:0] id, input logic [31:0] v);
    logic [39:0] msg;
    logic [7:0]  crc;
    logic        fb;
    msg = {id, v[7:0], v[15:8], v[23:16], v[31:24]};
    crc = 8'h00;
    fb  = 1'b0;
`ifdef ICEBUS_CRC8_EN
    // Bit-serial polynomial division, message MSB first.
    for (int i = 39; i >= 0; i--) begin
      fb  = crc[7] ^ msg[i];
      crc = {crc[6:0], 1'b0};
      if (fb) crc = crc ^ 8'h07;
    end
`else
    for (int i = 0; i < 5; i++) crc = crc ^ msg[8*i +: 8];
`endif
    return crc;
  endfunction

  function automatic logic [55:0] mk_cmd(input logic [7:0] id, input logic [31:0] v,
                                         input logic [7:0] chk);
    return {chk, v, id, 8'h55};
  endfunction

  // ---------------- checks ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int v, input int lo, input int hi);
    vectors++;
    assert (v >= lo && v <= hi) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] cur, input logic [7:0] chk);
    logic [55:0] e;
    e = {chk, cur, 8'h01, 8'hAA};
    check({tag, " rsp_len"}, 64'(rsp_q.size()), 64'd7);
    if (rsp_q.size() >= 7)
      for (int i = 0; i < 7; i++)
        check($sformatf("%s rsp_byte%0d", tag, i), 64'(rsp_q[i]), 64'(e[8*i +: 8]));
  endtask

  task automatic clear_rsp();
    rsp_q.delete();
    rsp_t.delete();
  endtask

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop_ok) repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [55:0] f, input int nbytes, input int bad_idx,
                            input int gap);
    for (int i = 0; i < nbytes; i++) begin
      send_byte(f[8*i +: 8], i != bad_idx);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      @(negedge clk);
      if (i >= 200 && !tx_enable) ok = 1'b1;
    end
    vectors++;
    assert (ok) else begin
      miscompares++;
      $error("FAIL %s: response not finished within 6000 cycles", tag);
    end
  endtask

  initial begin : main
    logic [7:0]  c1, r1, id, chk;
    logic [31:0] exp_sp, v, cur, cur_b, v_b;
    int sv0, fe0, tr0, t_end, pick;
    bit bad, hit, resp;

`ifdef ICEBUS_CRC8_EN
    c1 = ref_chk(8'h01, 32'h78563412);
    r1 = ref_chk(8'h01, 32'hDEADBEEF);
`else
    c1 = 8'h09;
    r1 = 8'h23;
`endif

    // Reset state
    reset = 1'b1; rx = 1'b1; current_in = '0;
    repeat (5) @(negedge clk);
    check("rst tx", 64'(tx), 64'd1);
    check("rst tx_enable", 64'(tx_enable), 64'd0);
    check("rst setpoint", 64'(setpoint), 64'd0);
    check("rst setpoint_valid", 64'(setpoint_valid), 64'd0);
    check("rst frame_error", 64'(frame_error), 64'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    clear_rsp();

    // Good addressed frame
    current_in = 32'hDEADBEEF;
    sv0 = sv_cnt; fe0 = fe_cnt; tr0 = ten_rise;
    send_frame(mk_cmd(8'h01, 32'h78563412, c1), 7, -1, 0);
    current_in = $urandom;           // must not affect the latched value
    wait_done("good");
    check("good setpoint", 64'(setpoint), 64'h78563412);
    check("good sv_pulses", 64'(sv_cnt - sv0), 64'd1);
    check("good fe_pulses", 64'(fe_cnt - fe0), 64'd0);
    check("good ten_rises", 64'(ten_rise - tr0), 64'd1);
    check_rsp("good", 32'hDEADBEEF, r1);
    if (rsp_t.size() >= 7) begin
      check_rng("good turnaround", rsp_t[0] - sv_cyc, 96, 102);
      check_rng("good release", ten_fall_cyc - (rsp_t[6] + 10 * CPB), 48, 52);
    end
    clear_rsp();
    exp_sp = 32'h78563412;

    // Bad checksum
    sv0 = sv_cnt; fe0 = fe_cnt; tr0 = ten_rise;
    send_frame(mk_cmd(8'h01, 32'h78563412, c1 ^ 8'h01), 7, -1, 0);
    repeat (300) @(negedge clk);
    check("badchk fe_pulses", 64'(fe_cnt - fe0), 64'd1);
    check("badchk sv_pulses", 64'(sv_cnt - sv0), 64'd0);
    check("badchk setpoint", 64'(setpoint), 64'(exp_sp));
    check("badchk ten_rises", 64'(ten_rise - tr0), 64'd0);

    // Broadcast
    sv0 = sv_cnt; fe0 = fe_cnt; tr0 = ten_rise;
    send_frame(mk_cmd(8'hFF, 32'h00000001, ref_chk(8'hFF, 32'h1)), 7, -1, 0);
    repeat (300) @(negedge clk);
    exp_sp = 32'h1;
    check("bcast setpoint", 64'(setpoint), 64'(exp_sp));
    check("bcast sv_pulses", 64'(sv_cnt - sv0), 64'd1);
    check("bcast ten_rises", 64'(ten_rise - tr0), 64'd0);
    check("bcast rsp_len", 64'(rsp_q.size()), 64'd0);

    // Other node
    v = $urandom;
    sv0 = sv_cnt; fe0 = fe_cnt; tr0 = ten_rise;
    send_frame(mk_cmd(8'h02, v, ref_chk(8'h02, v)), 7, -1, 0);
    repeat (300) @(negedge clk);
    check("other setpoint", 64'(setpoint), 64'(exp_sp));
    check("other sv_pulses", 64'(sv_cnt - sv0), 64'd0);
    check("other fe_pulses", 64'(fe_cnt - fe0), 64'd0);
    check("other ten_rises", 64'(ten_rise - tr0), 64'd0);

    // Stop bit low on D1, then recovery with a valid frame
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_frame(mk_cmd(8'h01, v, ref_chk(8'h01, v)), 4, 3, 0);
    repeat (100) @(negedge clk);
    check("stoperr fe_pulses", 64'(fe_cnt - fe0), 64'd1);
    check("stoperr sv_pulses", 64'(sv_cnt - sv0), 64'd0);
    v = $urandom; cur = $urandom; current_in = cur;
    send_frame(mk_cmd(8'h01, v, ref_chk(8'h01, v)), 7, -1, 3);
    wait_done("recover");
    exp_sp = v;
    check("recover setpoint", 64'(setpoint), 64'(exp_sp));
    check_rsp("recover", cur, ref_chk(8'h01, cur));
    clear_rsp();

    // Mid-frame timeout
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_frame(mk_cmd(8'h01, 32'h00000012, 8'h00), 3, -1, 0);
    t_end = cyc;
    repeat (1000) @(negedge clk);
    check("timeout fe_pulses", 64'(fe_cnt - fe0), 64'd1);
    check("timeout sv_pulses", 64'(sv_cnt - sv0), 64'd0);
    check_rng("timeout latency", fe_cyc - t_end, 500, 560);

    // Second addressed frame arriving during the response
    v = $urandom; cur = $urandom; v_b = $urandom; cur_b = $urandom;
    current_in = cur;
    sv0 = sv_cnt; tr0 = ten_rise;
    send_frame(mk_cmd(8'h01, v, ref_chk(8'h01, v)), 7, -1, 0);
    current_in = cur_b;
    send_frame(mk_cmd(8'h01, v_b, ref_chk(8'h01, v_b)), 7, -1, 0);
    wait_done("overlap");
    repeat (200) @(negedge clk);
    exp_sp = v_b;
    check("overlap setpoint", 64'(setpoint), 64'(exp_sp));
    check("overlap sv_pulses", 64'(sv_cnt - sv0), 64'd2);
    check("overlap ten_rises", 64'(ten_rise - tr0), 64'd1);
    check_rsp("overlap", cur, ref_chk(8'h01, cur));
    clear_rsp();

    // Reset during byte 3 of a response
    v = $urandom; cur = $urandom; current_in = cur;
    send_frame(mk_cmd(8'h01, v, ref_chk(8'h01, v)), 7, -1, 0);
    for (int i = 0; i < 3000 && rsp_q.size() < 3; i++) @(negedge clk);
    check("rstmid reached byte3", 64'(rsp_q.size() >= 3), 64'd1);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstmid tx", 64'(tx), 64'd1);
    check("rstmid tx_enable", 64'(tx_enable), 64'd0);
    check("rstmid setpoint", 64'(setpoint), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (700) @(negedge clk);
    clear_rsp();
    v = $urandom; cur = $urandom; current_in = cur;
    send_frame(mk_cmd(8'h01, v, ref_chk(8'h01, v)), 7, -1, 0);
    wait_done("after_rst");
    exp_sp = v;
    check("after_rst setpoint", 64'(setpoint), 64'(exp_sp));
    check_rsp("after_rst", cur, ref_chk(8'h01, cur));
    clear_rsp();

    // Randomised frames
    for (int n = 0; n < 2; n++) begin
      pick = $urandom_range(0, 2);
      id   = (pick == 0) ? 8'h01 : (pick == 1) ? 8'hFF : 8'h02;
      bad  = ($urandom_range(0, 3) == 0);
      v    = $urandom; cur = $urandom; current_in = cur;
      chk  = ref_chk(id, v) ^ (bad ? 8'h5A : 8'h00);
      hit  = (id == 8'h01) || (id == 8'hFF);
      resp = (id == 8'h01) && !bad;
      sv0 = sv_cnt; fe0 = fe_cnt; tr0 = ten_rise;
      send_frame(mk_cmd(id, v, chk), 7, -1, $urandom_range(0, 20));
      current_in = $urandom;
      if (resp) wait_done($sformatf("rand%0d", n));
      else      repeat (300) @(negedge clk);
      if (hit && !bad) exp_sp = v;
      check($sformatf("rand%0d setpoint", n), 64'(setpoint), 64'(exp_sp));
      check($sformatf("rand%0d sv_pulses", n), 64'(sv_cnt - sv0), 64'(hit && !bad));
      check($sformatf("rand%0d fe_pulses", n), 64'(fe_cnt - fe0), 64'(hit && bad));
      check($sformatf("rand%0d ten_rises", n), 64'(ten_rise - tr0), 64'(resp));
      if (resp) check_rsp($sformatf("rand%0d", n), cur, ref_chk(8'h01, cur));
      else      check($sformatf("rand%0d rsp_len", n), 64'(rsp_q.size()), 64'd0);
      clear_rsp();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
